// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue/writeback controller for the registered 16-bit ALU. It accepts
//   16-bit instruction words over valid/ready and reads operands from an
//   internal 8x16 register file. It drives the ALU function code and the
//   signed operands, waits ALU_LAT cycles, then writes the result (and the
//   remainder for a divide) back. At most one ALU op is in flight.
//
// Parameters
//   ALU_LAT  cycles from the ALU sampling edge to a valid result (1..15)
//   REM_REG  register that receives the remainder on divide
//
// Build option
//   ALU_ISSUE_DIV0_TRAP_EN  when defined, a divide whose rs2 reads zero is
//                           rejected at accept (err pulse, no issue).
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   instr_valid/instr_ready   instruction handshake; ready == IDLE
//   instr[15:0]               [15:12] funct, [11:9] rd, [8:6] rs1,
//                             [5:3] rs2; LDI immediate in [8:0]
//   alu_funct/alu_op1/alu_op2 to the ALU, held from ISSUE through WAIT
//   alu_result/alu_remainder  from the ALU
//   rd_addr/rd_data           combinational debug read port
//   busy                      high in ISSUE/WAIT
//   err                       one-cycle pulse per rejected instruction
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int REM_REG = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [15:0]        instr,
  output logic [3:0]         alu_funct,
  output logic signed [15:0] alu_op1,
  output logic signed [15:0] alu_op2,
  input  logic signed [15:0] alu_result,
  input  logic [15:0]        alu_remainder,
  input  logic [2:0]         rd_addr,
  output logic [15:0]        rd_data,
  output logic               busy,
  output logic               err
);

  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_MUL  = 4'b0100;
  localparam logic [3:0] F_DIV  = 4'b0101;
  localparam logic [3:0] F_MOVE = 4'b0111;
  localparam logic [3:0] F_SWAP = 4'b1000;
  localparam logic [3:0] F_LDI  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  // Fields of the in-flight op needed at writeback. rs2's value is not kept
  // here: the swap writeback reuses the held alu_op2.
  typedef struct packed {
    logic [3:0] funct;
    logic [2:0] rd;
    logic [2:0] rs1;
  } op_t;

  state_t            state, state_nx;
  logic [3:0]        cnt;
  op_t               cur;
  logic [7:0][15:0]  regs;
  logic [7:0]        we;
  logic [7:0][15:0]  wd;

  // ---------------- decode ----------------
  logic [3:0]  i_funct;
  logic [2:0]  i_rd, i_rs1, i_rs2;
  logic        unused_instr;
  logic        accept, is_alu, is_ldi, trap;
  logic        go_alu, go_ldi, go_rej, wb;

  assign i_funct      = instr[15:12];
  assign i_rd         = instr[11:9];
  assign i_rs1        = instr[8:6];
  assign i_rs2        = instr[5:3];
  assign unused_instr = ^instr[2:0];

  assign instr_ready = (state == S_IDLE);
  assign busy        = ~instr_ready;
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    is_alu = 1'b0;
    case (i_funct)
      F_ADD, F_SUB, F_MUL, F_DIV, F_MOVE, F_SWAP: is_alu = 1'b1;
      default:                                    is_alu = 1'b0;
    endcase
  end

  assign is_ldi = (i_funct == F_LDI);

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign trap = (i_funct == F_DIV) && (regs[i_rs2] == 16'h0000);
`else
  assign trap = 1'b0;
`endif

  assign go_alu = accept & is_alu & ~trap;
  assign go_ldi = accept & is_ldi;
  assign go_rej = accept & ~go_alu & ~go_ldi;

  // Writeback happens on the edge that ends the last WAIT cycle.
  assign wb = (state == S_WAIT) && (cnt == 4'd1);

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go_alu) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cur       <= '0;
      alu_funct <= 4'd0;
      alu_op1   <= 16'sd0;
      alu_op2   <= 16'sd0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= go_rej;
      if (state == S_ISSUE)     cnt <= 4'(ALU_LAT);
      else if (state == S_WAIT) cnt <= cnt - 4'd1;
      // ALU inputs only change on an accepted ALU op, so they stay stable
      // through ISSUE/WAIT and keep their last value while idle.
      if (go_alu) begin
        cur.funct <= i_funct;
        cur.rd    <= i_rd;
        cur.rs1   <= i_rs1;
        alu_funct <= i_funct;
        alu_op1   <= $signed(regs[i_rs1]);
        alu_op2   <= $signed(regs[i_rs2]);
      end
    end
  end

  // ---------------- register file write ports ----------------
  // Writes are resolved per register in priority order; the rd write is
  // applied last so it overrides the remainder (div) and rs1 (swap) writes.
  // LDI and writeback never coincide because LDI is only accepted in IDLE.
  always_comb begin
    we = '0;
    wd = '0;
    for (int i = 0; i < 8; i++) begin
      if (go_ldi && (i_rd == 3'(i))) begin
        we[i] = 1'b1;
        wd[i] = {{7{instr[8]}}, instr[8:0]};
      end
      if (wb) begin
        if ((cur.funct == F_DIV) && (i == REM_REG)) begin
          we[i] = 1'b1;
          wd[i] = alu_remainder;
        end
        if ((cur.funct == F_SWAP) && (cur.rs1 == 3'(i))) begin
          we[i] = 1'b1;
          wd[i] = alu_op2;
        end
        if (cur.rd == 3'(i)) begin
          we[i] = 1'b1;
          wd[i] = alu_result;
        end
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       regs[g] <= 16'h0000;
      else if (we[g]) regs[g] <= wd[g];
    end
  end

  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int LAT = 1;
  localparam int REM = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic               instr_ready;
  logic [15:0]        instr;
  logic [3:0]         alu_funct;
  logic signed [15:0] alu_op1, alu_op2;
  logic signed [15:0] alu_result;
  logic [15:0]        alu_remainder;
  logic [2:0]         rd_addr;
  logic [15:0]        rd_data;
  logic               busy, err;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] mdl [8];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LAT(LAT), .REM_REG(REM)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_funct(alu_funct), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_remainder(alu_remainder),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .err(err)
  );

  // Behavioural ALU: {remainder, result}. Divide by zero returns all-ones
  // quotient and the dividend as remainder.
  function automatic logic [31:0] alu_f(input logic [3:0] f,
                                        input logic signed [15:0] a,
                                        input logic signed [15:0] b);
    int sa, sb, q, r;
    logic [15:0] res, rem;
    sa = a; sb = b; res = 16'h0; rem = 16'h0;
    case (f)
      4'h0: res = 16'(sa + sb);
      4'h1: res = 16'(sa - sb);
      4'h4: res = 16'(sa * sb);
      4'h5: if (sb == 0) begin res = 16'hFFFF; rem = a; end
            else begin q = sa / sb; r = sa % sb; res = q[15:0]; rem = r[15:0]; end
      4'h7, 4'h8: res = a;
      default: res = 16'h0;
    endcase
    return {rem, res};
  endfunction

  // Registered ALU with LAT stages; samples on the edge that ends ISSUE.
  logic [31:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= alu_f(alu_funct, alu_op1, alu_op2);
    for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
  end
  assign alu_result    = apipe[LAT-1][15:0];
  assign alu_remainder = apipe[LAT-1][31:16];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), rd_data, mdl[i]);
    end
  endtask

  task automatic peek(input logic [2:0] a, output logic [15:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [8:0] imm);
    return {4'hF, d, imm};
  endfunction

  function automatic logic [15:0] op(input logic [3:0] f, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {f, d, s1, s2, 3'b000};
  endfunction

  // Drives one instruction, checks handshake/ALU-side outputs cycle by cycle
  // and updates the register model when the instruction completes.
  task automatic do_instr(input logic [15:0] w);
    logic [3:0]  f;
    logic [2:0]  d, s1, s2;
    logic [15:0] o1, o2;
    logic [31:0] ar;
    bit          rej;
    f = w[15:12]; d = w[11:9]; s1 = w[8:6]; s2 = w[5:3];
    @(negedge clk);
    chk("ready_idle", 16'(instr_ready), 16'd1);
    instr = w; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    o1 = mdl[s1]; o2 = mdl[s2];
    if (f == 4'hF) begin
      mdl[d] = {{7{w[8]}}, w[8:0]};
      chk("ldi_err", 16'(err), 16'd0);
      chk("ldi_busy", 16'(busy), 16'd0);
    end else begin
      rej = !(f inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8});
`ifdef ALU_ISSUE_DIV0_TRAP_EN
      if (f == 4'h5 && o2 == 16'h0) rej = 1'b1;
`endif
      if (rej) begin
        chk("rej_err", 16'(err), 16'd1);
        chk("rej_ready", 16'(instr_ready), 16'd1);
      end else begin
        chk("iss_busy", 16'(busy), 16'd1);
        chk("iss_ready", 16'(instr_ready), 16'd0);
        chk("iss_funct", 16'(alu_funct), 16'(f));
        chk("iss_op1", alu_op1, o1);
        chk("iss_op2", alu_op2, o2);
        ar = alu_f(f, o1, o2);
        repeat (LAT) begin
          @(posedge clk); #1;
          chk("wait_ready", 16'(instr_ready), 16'd0);
          chk("wait_op1", alu_op1, o1);
        end
        @(posedge clk); #1;
        chk("done_ready", 16'(instr_ready), 16'd1);
        chk("done_busy", 16'(busy), 16'd0);
        chk("done_err", 16'(err), 16'd0);
        case (f)
          4'h5: begin mdl[REM] = ar[31:16]; mdl[d] = ar[15:0]; end
          4'h8: begin mdl[s1] = o2; mdl[d] = o1; end
          default: mdl[d] = ar[15:0];
        endcase
      end
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  f;
    rst = 1'b0; instr_valid = 1'b0; instr = 16'h0; rd_addr = 3'd0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_funct", 16'(alu_funct), 16'd0);
    chk("rst_op1", alu_op1, 16'd0);
    chk("rst_op2", alu_op2, 16'd0);
    check_regs("rst");

    // add 5 + -3
    do_instr(ldi(3'd1, 9'd5));
    do_instr(ldi(3'd2, 9'h1FD));
    do_instr(op(4'h0, 3'd3, 3'd1, 3'd2));
    peek(3'd3, v); chk("add_r3", v, 16'h0002);
    check_regs("add");

    // divide, remainder into r7, then quotient wins on rd==r7
    do_instr(ldi(3'd1, 9'd17));
    do_instr(ldi(3'd5, 9'd5));
    do_instr(op(4'h5, 3'd4, 3'd1, 3'd5));
    peek(3'd4, v); chk("div_q", v, 16'd3);
    peek(3'd7, v); chk("div_rem", v, 16'd2);
    do_instr(op(4'h5, 3'd7, 3'd1, 3'd5));
    peek(3'd7, v); chk("div_rdrem", v, 16'd3);
    check_regs("div");

    // swap: true exchange, then rd==rs1 keeps rs1
    do_instr(ldi(3'd1, 9'd5));
    do_instr(ldi(3'd2, 9'h1FD));
    do_instr(op(4'h8, 3'd2, 3'd1, 3'd2));
    peek(3'd2, v); chk("swap_r2", v, 16'd5);
    peek(3'd1, v); chk("swap_r1", v, 16'hFFFD);
    do_instr(op(4'h8, 3'd1, 3'd1, 3'd2));
    peek(3'd1, v); chk("swap_rd_rs1", v, 16'hFFFD);
    check_regs("swap");

    // rejected funct held valid: one err cycle per instruction
    @(negedge clk);
    instr = op(4'h2, 3'd3, 3'd1, 3'd2); instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rej_held_err", 16'(err), 16'd1);
      chk("rej_held_ready", 16'(instr_ready), 16'd1);
    end
    @(negedge clk); instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rej_drop_err", 16'(err), 16'd0);
    check_regs("rej");

    // divide by zero
    do_instr(ldi(3'd6, 9'd0));
    do_instr(op(4'h5, 3'd3, 3'd1, 3'd6));
    check_regs("div0");

    // reset during WAIT of an add
    do_instr(ldi(3'd1, 9'd5));
    do_instr(ldi(3'd2, 9'h1FD));
    @(negedge clk);
    instr = op(4'h0, 3'd3, 3'd1, 3'd2); instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 16'(busy), 16'd1);
    rst = 1'b0; #1;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_ready", 16'(instr_ready), 16'd1);
    chk("mid_rst_err", 16'(err), 16'd0);
    check_regs("mid_rst");
    @(negedge clk); rst = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("post_rst_busy", 16'(busy), 16'd0);
    check_regs("post_rst");

    // randomized mix
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 11))
        0: f = 4'h0;  1: f = 4'h1;  2: f = 4'h4;  3: f = 4'h5;
        4: f = 4'h7;  5: f = 4'h8;  6, 7, 8: f = 4'hF;
        default: f = 4'($urandom_range(0, 15));
      endcase
      if (f == 4'hF) do_instr(ldi(3'($urandom_range(0, 7)), 9'($urandom_range(0, 511))));
      else do_instr(op(f, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7))));
      check_regs("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
